navigate: RTL and testbench

Motion sequencer directly upstream of the heading PID. It accepts heading and move commands from the command processor and drives the PID's `moving` and `frwrd_spd` inputs. It ramps forward speed up and down on gyro update strobes and decides when a move ends: on a side opening or on a forward obstruction. It reports completion with a one-cycle `mv_cmplt` pulse and gates sensor fusion via `en_fusion`.

---
 rtl/nav_pkg.sv | 31 +++
 rtl/spd_ramp.sv | 59 +++++
 rtl/navigate.sv | 147 ++++++++++++++
 tb/tb_navigate.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nav_pkg
// Description : Shared types and constants for the navigate motion sequencer.
//               nav_state_t  - sequencer state encoding
//               spd_op_t     - speed-register operation select
//               DECEL_MULT / BRAKE_MULT - decel step multipliers of ACCEL
// Revision    : 1.0 - initial release
// ============================================================================
package nav_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDNG    = 3'd1,
        ST_RAMP_UP = 3'd2,
        ST_DECEL   = 3'd3,
        ST_BRAKE   = 3'd4
    } nav_state_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_BRK  = 2'd3
    } spd_op_t;

    localparam int DECEL_MULT = 2;
    localparam int BRAKE_MULT = 4;

endpackage
`default_nettype wire

// File: rtl/spd_ramp.sv
`default_nettype none
// ============================================================================
// Module      : spd_ramp
// Description : 11-bit forward-speed register with saturating ramp.
//               clk  in  1   system clock
//               rst  in  1   synchronous active-high reset
//               clr  in  1   force speed to zero
//               op   in  2   hold / inc (+ACCEL, capped at MAX_SPD) /
//                            dec (-DECEL_MULT*ACCEL) / brk (-BRAKE_MULT*ACCEL),
//                            decrements floor at zero
//               spd  out 11  registered speed
// Revision    : 1.0 - initial release
// ============================================================================
module spd_ramp
    import nav_pkg::*;
#(
    parameter logic [10:0] MAX_SPD = 11'h2A0,
    parameter logic [10:0] ACCEL   = 11'h018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  spd_op_t     op,
    output logic [10:0] spd
);

    localparam logic [12:0] C_DEC_STEP = 13'(DECEL_MULT) * {2'b00, ACCEL};
    localparam logic [12:0] C_BRK_STEP = 13'(BRAKE_MULT) * {2'b00, ACCEL};

    logic [10:0] r_spd;
    logic [11:0] w_sum;
    logic [12:0] w_step;
    logic [12:0] w_spd_ext;
    logic [12:0] w_diff;

    // One extra bit on the sum means the comparison against the ceiling
    // is valid even when the raw addition would overflow 11 bits.
    assign w_sum     = {1'b0, r_spd} + {1'b0, ACCEL};
    assign w_step    = (op == OP_BRK) ? C_BRK_STEP : C_DEC_STEP;
    assign w_spd_ext = {2'b00, r_spd};
    assign w_diff    = w_spd_ext - w_step;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_spd <= '0;
        end else begin
            case (op)
                OP_INC:  r_spd <= (w_sum > {1'b0, MAX_SPD}) ? MAX_SPD : w_sum[10:0];
                OP_DEC,
                OP_BRK:  r_spd <= (w_spd_ext < w_step) ? 11'd0 : w_diff[10:0];
                default: r_spd <= r_spd;
            endcase
        end
    end

    assign spd = r_spd;

endmodule
`default_nettype wire

// File: rtl/navigate.sv
`default_nettype none
// ============================================================================
// Module      : navigate
// Description : Motion sequencer feeding the heading PID. Runs heading
//               changes and forward moves, ramps speed on gyro strobes and
//               ends a move on a selected side opening or a forward
//               obstruction.
//               clk, rst                 clock / sync active-high reset
//               strt_hdng, strt_mv       command pulses (IDLE only)
//               stp_lft, stp_rght        stop-at-opening selects
//               hdng_vld                 gyro update strobe
//               at_hdng                  PID heading reached
//               lft_opn, rght_opn        side openings
//               frwrd_opn                path ahead clear
//               moving                   high outside IDLE
//               frwrd_spd [10:0]         registered forward speed
//               en_fusion                speed above half of MAX_SPD
//               mv_cmplt                 one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module navigate
    import nav_pkg::*;
#(
    parameter logic [10:0] MAX_SPD = 11'h2A0,
    parameter logic [10:0] ACCEL   = 11'h018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_hdng,
    input  logic        strt_mv,
    input  logic        stp_lft,
    input  logic        stp_rght,
    input  logic        hdng_vld,
    input  logic        at_hdng,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    output logic        moving,
    output logic [10:0] frwrd_spd,
    output logic        en_fusion,
    output logic        mv_cmplt
);

    nav_state_t r_state;
    nav_state_t w_state_nxt;
    spd_op_t    w_op;
    logic       w_clr;
    logic       w_cmplt;
    logic       r_lft_q;
    logic       r_rght_q;
    logic       r_mv_cmplt;
    logic       w_lft_rise;
    logic       w_rght_rise;
    logic       w_side_stop;
    logic       w_spd_zero;

    // Edge registers come out of reset high so an opening that is already
    // present is never mistaken for a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lft_q  <= 1'b1;
            r_rght_q <= 1'b1;
        end else begin
            r_lft_q  <= lft_opn;
            r_rght_q <= rght_opn;
        end
    end

    assign w_lft_rise  = lft_opn  & ~r_lft_q;
    assign w_rght_rise = rght_opn & ~r_rght_q;
    assign w_side_stop = (stp_lft & w_lft_rise) | (stp_rght & w_rght_rise);
    assign w_spd_zero  = (frwrd_spd == 11'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_op        = OP_HOLD;
        w_clr       = 1'b0;
        w_cmplt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (strt_hdng)    w_state_nxt = ST_HDNG;
                else if (strt_mv) w_state_nxt = ST_RAMP_UP;
            end
            ST_HDNG: begin
                w_clr = 1'b1;
                if (at_hdng) begin
                    w_state_nxt = ST_IDLE;
                    w_cmplt     = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                // The increment still lands on the edge that takes an exit.
                if (hdng_vld)         w_op        = OP_INC;
                if (!frwrd_opn)       w_state_nxt = ST_BRAKE;
                else if (w_side_stop) w_state_nxt = ST_DECEL;
            end
            ST_DECEL: begin
                if (hdng_vld) w_op = OP_DEC;
                if (w_spd_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_cmplt     = 1'b1;
                end else if (!frwrd_opn) begin
                    w_state_nxt = ST_BRAKE;
                end
            end
            ST_BRAKE: begin
                if (hdng_vld) w_op = OP_BRK;
                if (w_spd_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_cmplt     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mv_cmplt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mv_cmplt <= w_cmplt;
        end
    end

    spd_ramp #(
        .MAX_SPD (MAX_SPD),
        .ACCEL   (ACCEL)
    ) u_spd_ramp (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .op  (w_op),
        .spd (frwrd_spd)
    );

    assign moving    = (r_state != ST_IDLE);
    assign en_fusion = (frwrd_spd > (MAX_SPD >> 1));
    assign mv_cmplt  = r_mv_cmplt;

endmodule
`default_nettype wire

// File: tb/tb_navigate.sv
`default_nettype none
// ============================================================================
// Module      : tb_navigate
// Description : Scoreboard bench for navigate. Stimulus pushes the expected
//               sequence of speed changes and completion pulses; a negedge
//               monitor pops and compares each event the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_navigate;

    typedef struct packed {
        logic        cmplt;
        logic [10:0] spd;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght, hdng_vld, at_hdng;
    logic        lft_opn, rght_opn, frwrd_opn;
    logic        moving, en_fusion, mv_cmplt;
    logic [10:0] frwrd_spd;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    bit   mon_en = 1'b0;
    logic [10:0] prev_spd = '0;

    always #5 clk = ~clk;

    navigate dut (
        .clk       (clk),
        .rst       (rst),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .hdng_vld  (hdng_vld),
        .at_hdng   (at_hdng),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .moving    (moving),
        .frwrd_spd (frwrd_spd),
        .en_fusion (en_fusion),
        .mv_cmplt  (mv_cmplt)
    );

    function automatic void push_spd(input logic [10:0] v);
        ev_t e;
        e.cmplt = 1'b0;
        e.spd   = v;
        exp_q.push_back(e);
    endfunction

    function automatic void push_cmplt();
        ev_t e;
        e.cmplt = 1'b1;
        e.spd   = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void check_ev(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected cmplt=%0b spd=%h at %0t, nothing expected",
                     got.cmplt, got.spd, $time);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                errors++;
                $display("FAIL event: got cmplt=%0b spd=%h, expected cmplt=%0b spd=%h at %0t",
                         got.cmplt, got.spd, e.cmplt, e.spd, $time);
            end
        end
    endfunction

    // Monitor: every speed change and every cycle of mv_cmplt is an event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (frwrd_spd !== prev_spd) begin
                check_ev({1'b0, frwrd_spd});
                prev_spd = frwrd_spd;
            end
            if (mv_cmplt !== 1'b0)
                check_ev({1'b1, 11'h000});
        end
    end

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_vld(input int n);
        repeat (n) begin
            hdng_vld = 1'b1;
            tick(1);
            hdng_vld = 1'b0;
            tick(1);
        end
    endtask

    task automatic pulse_mv();
        strt_mv = 1'b1;
        tick(1);
        strt_mv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [10:0] e_spd;
        rst = 1'b1; strt_hdng = 0; strt_mv = 0; stp_lft = 0; stp_rght = 0;
        hdng_vld = 0; at_hdng = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
        do_reset();
        chk("reset_spd",    frwrd_spd, 11'h000);
        chk("reset_moving", {10'd0, moving},    11'd0);
        chk("reset_cmplt",  {10'd0, mv_cmplt},  11'd0);
        chk("reset_fusion", {10'd0, en_fusion}, 11'd0);
        prev_spd = 11'h000;
        mon_en   = 1'b1;

        // Ramp-up with saturation at 0x2A0 (28 steps of 0x18, then hold).
        for (int k = 1; k <= 28; k++) push_spd(11'(k * 24));
        pulse_mv();
        chk("ramp_moving", {10'd0, moving}, 11'd1);
        for (int k = 1; k <= 30; k++) begin
            pulse_vld(1);
            e_spd = (k >= 28) ? 11'h2A0 : 11'(k * 24);
            chk("ramp_fusion", {10'd0, en_fusion}, {10'd0, (e_spd > 11'h150)});
        end
        chk("ramp_sat", frwrd_spd, 11'h2A0);

        // Left-opening stop: 0x270, 0x240, ... 0x000, then completion.
        for (int k = 1; k <= 14; k++) push_spd(11'(672 - k * 48));
        push_cmplt();
        stp_lft = 1'b1;
        lft_opn = 1'b1;
        tick(1);
        chk("decel_spd_hold", frwrd_spd, 11'h2A0);
        pulse_vld(14);
        chk("decel_cmplt", {10'd0, mv_cmplt}, 11'd1);
        chk("decel_moving", {10'd0, moving}, 11'd0);
        tick(1);
        chk("decel_cmplt_once", {10'd0, mv_cmplt}, 11'd0);
        lft_opn = 1'b0; stp_lft = 1'b0;
        tick(1);

        // Obstruction during DECEL at 0x240 -> BRAKE steps of 0x60.
        for (int k = 1; k <= 26; k++) push_spd(11'(k * 24));
        push_spd(11'h240);
        push_spd(11'h1E0); push_spd(11'h180); push_spd(11'h120);
        push_spd(11'h0C0); push_spd(11'h060); push_spd(11'h000);
        push_cmplt();
        pulse_mv();
        pulse_vld(26);
        stp_rght = 1'b1;
        rght_opn = 1'b1;
        tick(1);
        pulse_vld(1);
        chk("decel_step", frwrd_spd, 11'h240);
        frwrd_opn = 1'b0;
        tick(1);
        pulse_vld(6);
        chk("brake_moving", {10'd0, moving}, 11'd0);
        rght_opn = 1'b0; stp_rght = 1'b0; frwrd_opn = 1'b1;
        tick(2);

        // Brake clamp: from 0x018 a 0x60 step lands on zero.
        push_spd(11'h018); push_spd(11'h000); push_cmplt();
        pulse_mv();
        pulse_vld(1);
        frwrd_opn = 1'b0;
        tick(1);
        pulse_vld(1);
        chk("clamp_spd", frwrd_spd, 11'h000);
        tick(1);
        frwrd_opn = 1'b1;
        tick(2);

        // Heading change; strt_mv and hdng_vld during HDNG are ignored.
        push_cmplt();
        strt_hdng = 1'b1;
        tick(1);
        strt_hdng = 1'b0;
        chk("hdng_moving", {10'd0, moving}, 11'd1);
        pulse_mv();
        pulse_vld(5);
        tick(38);
        chk("hdng_spd", frwrd_spd, 11'h000);
        chk("hdng_no_cmplt", {10'd0, mv_cmplt}, 11'd0);
        at_hdng = 1'b1;
        tick(1);
        at_hdng = 1'b0;
        chk("hdng_cmplt", {10'd0, mv_cmplt}, 11'd1);
        chk("hdng_idle", {10'd0, moving}, 11'd0);
        tick(1);
        chk("hdng_cmplt_once", {10'd0, mv_cmplt}, 11'd0);
        chk("hdng_mv_ignored", {10'd0, moving}, 11'd0);

        // Opening present from reset is not an edge.
        lft_opn = 1'b1; stp_lft = 1'b1;
        do_reset();
        push_spd(11'h018); push_spd(11'h030); push_spd(11'h048);
        push_spd(11'h060); push_spd(11'h030); push_spd(11'h000);
        push_cmplt();
        pulse_mv();
        pulse_vld(3);
        chk("open_start_moving", {10'd0, moving}, 11'd1);
        lft_opn = 1'b0;
        tick(1);
        pulse_vld(1);
        lft_opn = 1'b1;
        tick(1);
        pulse_vld(2);
        chk("open_start_idle", {10'd0, moving}, 11'd0);
        lft_opn = 1'b0; stp_lft = 1'b0;
        tick(2);

        // Reset in the middle of BRAKE: clean IDLE, no completion pulse.
        for (int k = 1; k <= 5; k++) push_spd(11'(k * 24));
        push_spd(11'h018);
        push_spd(11'h000);
        pulse_mv();
        pulse_vld(5);
        frwrd_opn = 1'b0;
        tick(1);
        pulse_vld(1);
        chk("brk_pre_rst", frwrd_spd, 11'h018);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_spd",    frwrd_spd, 11'h000);
        chk("rst_moving", {10'd0, moving},   11'd0);
        chk("rst_cmplt",  {10'd0, mv_cmplt}, 11'd0);
        tick(1);
        chk("rst_no_pulse", {10'd0, mv_cmplt}, 11'd0);
        frwrd_opn = 1'b1;
        tick(3);

        chk("queue_drained", 11'(exp_q.size()), 11'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
